// File: rtl/lpm_pkg.sv
// Shared types for the LPM trie walker: node layout, flag bit positions, walker
// state encoding and the per-level key slicing helper.
package lpm_pkg;

   typedef struct packed {
      logic [31:0] c;  // flags
      logic [31:0] b;  // prefix result
      logic [31:0] a;  // child table base
   } lpm_node_t;

   localparam int unsigned LPM_FLAG_VALID = 0;
   localparam int unsigned LPM_FLAG_LEAF  = 1;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWait,
      StDone
   } lpm_state_e;

   // Zero-extended STRIDE-bit slice of the key for trie level lvl, taken MSB first.
   function automatic logic [31:0] lpm_key_slice(input logic [31:0] key,
                                                 input int unsigned lvl,
                                                 input int unsigned stride);
      logic [31:0] mask;
      int unsigned hi_bits;
      hi_bits = (lvl + 1) * stride;
      mask    = (stride >= 32) ? '1 : ((32'd1 << stride) - 32'd1);
      if (hi_bits > 32) begin
         return '0;
      end
      return (key >> (32 - hi_bits)) & mask;
   endfunction

endpackage

// File: rtl/lpm_walker.sv
// Longest-prefix-match trie walker: one lookup in flight, one node read per level.
// Optional statistics counters are built when LPM_WALKER_STATS_EN is defined.
module lpm_walker
   import lpm_pkg::*;
#(
   parameter int unsigned STRIDE    = 8,
   parameter int unsigned MAX_STEPS = 4,
   parameter logic [31:0] ROOT_BASE = 32'h0
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        in__ENA,
   input  logic [31:0] in_key,
   input  logic [31:0] in_id,
   output logic        in__RDY,
   output logic        mem_req__ENA,
   output logic [95:0] mem_req_v,
   input  logic        mem_req__RDY,
   output logic        mem_resAccept__ENA,
   input  logic        mem_resAccept__RDY,
   input  logic [95:0] mem_resValue,
   input  logic        mem_resValue__RDY,
   input  logic        out__ENA,
   output logic        out__RDY,
   output logic        out_hit,
   output logic [63:0] out_v,
   output logic [31:0] stat_lookups,
   output logic [31:0] stat_memReads
);

   lpm_state_e  state_q, state_d;
   logic [31:0] key_q, key_d;
   logic [31:0] id_q, id_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] step_q, step_d;
   logic [31:0] best_q, best_d;
   logic        hit_q, hit_d;

   lpm_node_t node;
   logic      in_fire, req_fire, acc_fire, last_step;
   logic      unused_c;

   assign node      = lpm_node_t'(mem_resValue);
   assign in_fire   = (state_q == StIdle) && in__ENA;
   assign req_fire  = (state_q == StReq) && mem_req__RDY;
   assign acc_fire  = (state_q == StWait) && mem_resValue__RDY && mem_resAccept__RDY;
   assign last_step = (step_q == 32'(MAX_STEPS - 1));
   assign unused_c  = ^node.c[31:2];

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= StIdle;
         key_q   <= '0;
         id_q    <= '0;
         addr_q  <= '0;
         step_q  <= '0;
         best_q  <= '0;
         hit_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         id_q    <= id_d;
         addr_q  <= addr_d;
         step_q  <= step_d;
         best_q  <= best_d;
         hit_q   <= hit_d;
      end
   end

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      id_d    = id_q;
      addr_d  = addr_q;
      step_d  = step_q;
      best_d  = best_q;
      hit_d   = hit_q;
      unique case (state_q)
         StIdle: begin
            if (in_fire) begin
               key_d   = in_key;
               id_d    = in_id;
               step_d  = '0;
               hit_d   = 1'b0;
               best_d  = '0;
               addr_d  = ROOT_BASE + lpm_key_slice(in_key, 0, STRIDE);
               state_d = StReq;
            end
         end
         StReq: begin
            if (req_fire) state_d = StWait;
         end
         StWait: begin
            if (acc_fire) begin
               // A leaf without a valid flag keeps the earlier best match.
               if (node.c[LPM_FLAG_VALID]) begin
                  hit_d  = 1'b1;
                  best_d = node.b;
               end
               if (node.c[LPM_FLAG_LEAF] || last_step) begin
                  state_d = StDone;
               end else begin
                  addr_d  = node.a + lpm_key_slice(key_q, step_q + 32'd1, STRIDE);
                  step_d  = step_q + 32'd1;
                  state_d = StReq;
               end
            end
         end
         StDone: begin
            if (out__ENA) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      in__RDY            = (state_q == StIdle);
      mem_req__ENA       = req_fire;
      mem_req_v          = (state_q == StReq) ? {step_q, key_q, addr_q} : '0;
      mem_resAccept__ENA = acc_fire;
      out__RDY           = (state_q == StDone);
      out_hit            = (state_q == StDone) ? hit_q : 1'b0;
      out_v              = (state_q == StDone) ? {best_q, id_q} : '0;
   end

`ifdef LPM_WALKER_STATS_EN
   logic [31:0] lookups_q, reads_q;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         lookups_q <= '0;
         reads_q   <= '0;
      end else begin
         if (in_fire)  lookups_q <= lookups_q + 32'd1;
         if (req_fire) reads_q   <= reads_q + 32'd1;
      end
   end

   assign stat_lookups  = lookups_q;
   assign stat_memReads = reads_q;
`else
   assign stat_lookups  = '0;
   assign stat_memReads = '0;
`endif

endmodule

// File: tb/tb_lpm_walker.sv
// Directed bench for lpm_walker with a behavioural 3-cycle node memory.
module tb_lpm_walker;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        in_ena = 1'b0;
   logic [31:0] in_key = '0;
   logic [31:0] in_id = '0;
   logic        in_rdy;
   logic        mem_req_ena;
   logic [95:0] mem_req_v;
   logic        mem_req_rdy = 1'b1;
   logic        res_acc_ena;
   logic        res_acc_rdy = 1'b1;
   logic [95:0] res_val;
   logic        res_rdy;
   logic        out_ena = 1'b0;
   logic        out_rdy;
   logic        out_hit;
   logic [63:0] out_v;
   logic [31:0] st_lookups;
   logic [31:0] st_reads;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   lpm_walker dut (
      .CLK               (clk),
      .nRST              (nrst),
      .in__ENA           (in_ena),
      .in_key            (in_key),
      .in_id             (in_id),
      .in__RDY           (in_rdy),
      .mem_req__ENA      (mem_req_ena),
      .mem_req_v         (mem_req_v),
      .mem_req__RDY      (mem_req_rdy),
      .mem_resAccept__ENA(res_acc_ena),
      .mem_resAccept__RDY(res_acc_rdy),
      .mem_resValue      (res_val),
      .mem_resValue__RDY (res_rdy),
      .out__ENA          (out_ena),
      .out__RDY          (out_rdy),
      .out_hit           (out_hit),
      .out_v             (out_v),
      .stat_lookups      (st_lookups),
      .stat_memReads     (st_reads)
   );

   // Behavioural node memory: response valid 3 cycles after the request fires.
   logic [95:0] mem [0:511];
   int          cnt = 0;
   logic [31:0] pend = '0;
   logic [31:0] rd_q [$];

   always @(posedge clk) begin
      if (!nrst) begin
         cnt <= 0;
      end else if (mem_req_ena) begin
         cnt  <= 3;
         pend <= mem_req_v[31:0];
         rd_q.push_back(mem_req_v[31:0]);
      end else if (cnt > 0) begin
         cnt <= cnt - 1;
      end
   end

   assign res_rdy = (cnt == 1);
   assign res_val = res_rdy ? mem[pend[8:0]] : '0;

   task automatic clear_mem();
      for (int i = 0; i < 512; i++) mem[i] = '0;
      rd_q.delete();
   endtask

   // Presents one lookup and counts edges until out__RDY (cycle 0 = the accept cycle).
   task automatic run_lookup(input logic [31:0] k, input logic [31:0] id, output int n);
      @(negedge clk);
      in_key = k;
      in_id  = id;
      in_ena = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         in_ena = 1'b0;
         n++;
      end while (!out_rdy && n < 100);
   endtask

   task automatic consume();
      @(negedge clk);
      out_ena = 1'b1;
      @(posedge clk);
      #1;
      out_ena = 1'b0;
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      nvec++;
      if (in_rdy !== 1'b1 || out_rdy !== 1'b0 || mem_req_ena !== 1'b0 || res_acc_ena !== 1'b0) begin
         nerr++;
         $display("FAIL reset_hs: in_rdy=%b out_rdy=%b req=%b acc=%b, need 1 0 0 0",
                  in_rdy, out_rdy, mem_req_ena, res_acc_ena);
      end
      nvec++;
      if (mem_req_v !== 96'h0 || out_v !== 64'h0 || out_hit !== 1'b0) begin
         nerr++;
         $display("FAIL reset_data: req_v=%h out_v=%h hit=%b, need zeros", mem_req_v, out_v, out_hit);
      end
      nvec++;
      if (st_lookups !== 32'h0 || st_reads !== 32'h0) begin
         nerr++;
         $display("FAIL reset_stats: lookups=%0d reads=%0d, need 0 0", st_lookups, st_reads);
      end
      @(negedge clk);
      nrst = 1'b1;
   endtask

   task automatic test_single_hit();
      int n;
      clear_mem();
      mem[9'h0A] = {32'd3, 32'h1234, 32'h0};
      run_lookup(32'h0A00_0000, 32'd7, n);
      nvec++;
      if (n !== 5) begin
         nerr++;
         $display("FAIL single_latency: got %0d cycles, need 5", n);
      end
      nvec++;
      if (out_hit !== 1'b1 || out_v !== {32'h1234, 32'd7}) begin
         nerr++;
         $display("FAIL single_result: hit=%b v=%h, need 1 %h", out_hit, out_v, {32'h1234, 32'd7});
      end
      nvec++;
      if (rd_q.size() != 1 || rd_q[0] !== 32'h0A) begin
         nerr++;
         $display("FAIL single_reads: count=%0d first=%h, need 1 at 0000000a", rd_q.size(),
                  (rd_q.size() > 0) ? rd_q[0] : 32'hx);
      end
      consume();
      nvec++;
      if (in_rdy !== 1'b1 || out_rdy !== 1'b0) begin
         nerr++;
         $display("FAIL single_return_idle: in_rdy=%b out_rdy=%b, need 1 0", in_rdy, out_rdy);
      end
   endtask

   task automatic test_two_level();
      int n;
      clear_mem();
      mem[9'h0A]  = {32'd1, 32'h11, 32'h100};
      mem[9'h10B] = {32'd2, 32'h99, 32'h0};
      run_lookup(32'h0A0B_0000, 32'd2, n);
      nvec++;
      if (n !== 9) begin
         nerr++;
         $display("FAIL two_latency: got %0d cycles, need 9", n);
      end
      nvec++;
      if (out_hit !== 1'b1 || out_v !== {32'h11, 32'd2}) begin
         nerr++;
         $display("FAIL two_result: hit=%b v=%h, need 1 %h", out_hit, out_v, {32'h11, 32'd2});
      end
      nvec++;
      if (rd_q.size() != 2 || rd_q[0] !== 32'h0A || rd_q[1] !== 32'h10B) begin
         nerr++;
         $display("FAIL two_reads: count=%0d, need 2 reads at 0000000a then 0000010b", rd_q.size());
      end
      consume();
   endtask

   task automatic test_max_depth();
      int n;
      clear_mem();
      run_lookup(32'h0102_0304, 32'd9, n);
      nvec++;
      if (n !== 17) begin
         nerr++;
         $display("FAIL depth_latency: got %0d cycles, need 17", n);
      end
      nvec++;
      if (out_hit !== 1'b0 || out_v !== {32'h0, 32'd9}) begin
         nerr++;
         $display("FAIL depth_result: hit=%b v=%h, need 0 %h", out_hit, out_v, {32'h0, 32'd9});
      end
      nvec++;
      if (rd_q.size() != 4 || rd_q[0] !== 32'h1 || rd_q[1] !== 32'h2 || rd_q[2] !== 32'h3 ||
          rd_q[3] !== 32'h4) begin
         nerr++;
         $display("FAIL depth_reads: count=%0d, need 4 reads at 1,2,3,4", rd_q.size());
      end
      consume();
   endtask

   task automatic test_stats();
      logic [31:0] exp_l, exp_r;
`ifdef LPM_WALKER_STATS_EN
      exp_l = 32'd3;
      exp_r = 32'd7;
`else
      exp_l = 32'd0;
      exp_r = 32'd0;
`endif
      nvec++;
      if (st_lookups !== exp_l || st_reads !== exp_r) begin
         nerr++;
         $display("FAIL stats: lookups=%0d reads=%0d, need %0d %0d", st_lookups, st_reads, exp_l, exp_r);
      end
   endtask

   task automatic test_leaf_miss();
      int n;
      clear_mem();
      mem[9'h0A] = {32'd2, 32'h0, 32'h0};
      run_lookup(32'h0A00_0000, 32'd5, n);
      nvec++;
      if (n !== 5 || out_hit !== 1'b0 || out_v !== {32'h0, 32'd5} || rd_q.size() != 1) begin
         nerr++;
         $display("FAIL leaf_miss: n=%0d hit=%b v=%h reads=%0d, need 5 0 %h 1", n, out_hit, out_v,
                  rd_q.size(), {32'h0, 32'd5});
      end
      consume();
   endtask

   task automatic test_backpressure();
      int n;
      clear_mem();
      mem[9'h33] = {32'd3, 32'hBEEF, 32'h0};
      run_lookup(32'h3300_0000, 32'hA5, n);
      for (int i = 0; i < 10; i++) begin
         nvec++;
         if (out_rdy !== 1'b1 || in_rdy !== 1'b0 || out_hit !== 1'b1 ||
             out_v !== {32'hBEEF, 32'hA5}) begin
            nerr++;
            $display("FAIL stall_hold[%0d]: out_rdy=%b in_rdy=%b hit=%b v=%h, need 1 0 1 %h", i,
                     out_rdy, in_rdy, out_hit, out_v, {32'hBEEF, 32'hA5});
         end
         @(posedge clk);
         #1;
      end
      consume();
   endtask

   task automatic test_reset_midwalk();
      int n;
      clear_mem();
      mem[9'h0A] = {32'd3, 32'h1234, 32'h0};
      @(negedge clk);
      in_key = 32'h0A00_0000;
      in_id  = 32'd1;
      in_ena = 1'b1;
      @(posedge clk);
      #1;
      in_ena = 1'b0;
      @(posedge clk);
      #1;
      nrst = 1'b0;
      @(posedge clk);
      #1;
      nvec++;
      if (in_rdy !== 1'b1 || out_rdy !== 1'b0) begin
         nerr++;
         $display("FAIL midwalk_reset: in_rdy=%b out_rdy=%b, need 1 0", in_rdy, out_rdy);
      end
      nrst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      nvec++;
      if (out_rdy !== 1'b0 || res_acc_ena !== 1'b0) begin
         nerr++;
         $display("FAIL midwalk_no_result: out_rdy=%b acc=%b, need 0 0", out_rdy, res_acc_ena);
      end
      run_lookup(32'h0A00_0000, 32'd4, n);
      nvec++;
      if (n !== 5 || out_hit !== 1'b1 || out_v !== {32'h1234, 32'd4}) begin
         nerr++;
         $display("FAIL midwalk_fresh: n=%0d hit=%b v=%h, need 5 1 %h", n, out_hit, out_v,
                  {32'h1234, 32'd4});
      end
      consume();
   endtask

   initial begin
      clear_mem();
      test_reset();
      test_single_hit();
      test_two_level();
      test_max_depth();
      test_stats();
      test_leaf_miss();
      test_backpressure();
      test_reset_midwalk();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/lpm_walker.md
# lpm_walker

Lookup engine that sits directly upstream of the LPM node memory. It accepts one longest-prefix-match lookup at a time and walks the multibit trie by issuing one node read per level over the memory's req/resAccept/resValue handshake. It keeps the best matching prefix result seen so far and presents {hit, value, id} to the downstream consumer. The memory side is port-compatible with the existing 96-bit node memory, whose response arrives 3 cycles after the request fires.

## Interface
Parameters:
- STRIDE, 8: key bits consumed per trie level.
- MAX_STEPS, 4: maximum levels walked; MAX_STEPS*STRIDE ≤ 32.
- ROOT_BASE, 32'h0: node address of the root table.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset, synchronous, active-low.
- in__ENA  in  1  lookup request; asserted only while in__RDY.
- in$key  in  32  lookup key.
- in$id  in  32  caller tag, returned unchanged.
- in__RDY  out  1  ready for a lookup.
- mem$req__ENA  out  1  node read fire.
- mem$req$v  out  96  {c=step, b=key, a=node address}.
- mem$req__RDY  in  1  memory can accept a request.
- mem$resAccept__ENA  out  1  consume the response.
- mem$resAccept__RDY  in  1  response can be consumed.
- mem$resValue  in  96  node {c=flags, b=result, a=child base}.
- mem$resValue__RDY  in  1  response valid.
- out__ENA  in  1  consumer takes the result; asserted only while out__RDY.
- out__RDY  out  1  result valid.
- out$hit  out  1  at least one valid prefix matched.
- out$v  out  64  {value[63:32], id[31:0]}.
- stat$lookups  out  32  lookups accepted (see Configuration).
- stat$memReads  out  32  node reads issued (see Configuration).

## Operation
States: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - in__RDY=1.
  - On in__ENA: latch key and id; step←0; hit←0; best←0; addr←ROOT_BASE + key[31 -: STRIDE]. Go to REQ.
- **REQ**
  - mem$req__ENA = mem$req__RDY.
  - mem$req$v = {32'(step), key, addr}.
  - When the request fires, go to WAIT.
- **WAIT**
  - mem$resAccept__ENA = mem$resValue__RDY & mem$resAccept__RDY.
  - On accept, decode the node: c[0] is the prefix-valid flag, c[1] is the leaf flag, other c bits are ignored.
  - If c[0]: hit←1, best←b.
  - If c[1], or step==MAX_STEPS-1: go to DONE.
  - Otherwise: addr←a + key[31-(step+1)*STRIDE -: STRIDE]; step←step+1; go to REQ.
- **DONE**
  - out__RDY=1; out$hit=hit; out$v={best, id}.
  - On out__ENA go to IDLE.
- Address arithmetic is 32-bit unsigned and wraps modulo 2^32. Slices are zero-extended.
- Only one lookup is in flight. in__RDY=0 outside IDLE, so in__ENA and out__ENA never coincide.
- A node with a leaf flag and no valid flag leaves the earlier best/hit unchanged.

## Timing
- Reset values:
  - state=IDLE; key, id, addr, step, best, hit = 0.
  - Outputs: in__RDY=1; every other output 0, including mem$req$v=0 and out$v=0.
- Reset is synchronous. Asserting nRST mid-walk (REQ or WAIT) returns to IDLE on the next edge and drops any pending response. The memory shares nRST, so both sides clear together.
- Latency with the 3-cycle memory, taking in__ENA at cycle 0:
  - REQ fires in cycle 1; response is accepted in cycle 4.
  - Each level costs 4 cycles. out__RDY rises in cycle 4L+1 for an L-level walk.
- mem$req__ENA and mem$resAccept__ENA are combinational from state and the memory RDY inputs. No other output has a combinational input path.
- A stalled consumer holds DONE and its outputs indefinitely.

## Configuration
- LPM_WALKER_STATS_EN defined:
  - stat$lookups increments on each in__ENA.
  - stat$memReads increments on each mem$req__ENA.
  - Both are 32-bit wrapping counters, cleared by reset.
- LPM_WALKER_STATS_EN undefined: no counter registers; the stat ports are tied to 0.

## Structure
- Shared package lpm_pkg holds:
  - lpm_node_t {c, b, a} packed 96-bit, with c in bits [95:64].
  - Constants LPM_FLAG_VALID=0 and LPM_FLAG_LEAF=1.
  - The walker state enum.
- Single module; no sub-module is warranted. Key slicing is an inline function in lpm_pkg.

## Test plan
The bench uses a behavioural node memory with the 3-cycle response latency.
- **Reset:** hold nRST=0 for 2 cycles → in__RDY=1, out__RDY=0, mem$req__ENA=0, stat counters 0.
- **Single-level hit:** mem[0x0A]={c=3, b=0x1234, a=0}; key 0x0A000000, id 7 → exactly one read at address 0x0A; out__RDY at cycle 5 with hit=1, out$v={0x1234, 7}.
- **Two-level, keep best:** mem[0x0A]={c=1, b=0x11, a=0x100}, mem[0x10B]={c=2, b=0x99, a=0}; key 0x0A0B0000 → reads at 0x0A then 0x10B; hit=1, value 0x11; out__RDY at cycle 9.
- **Miss and max depth:**
  - mem[0x0A]={c=2} → hit=0, value 0.
  - All nodes {c=0, a=0}, key 0x01020304 → 4 reads at 0x01, 0x02, 0x03, 0x04; hit=0; out__RDY at cycle 17.
- **Backpressure and reset:**
  - Hold out__ENA=0 for 10 cycles → outputs stable, in__RDY=0.
  - Assert nRST in WAIT → next cycle in IDLE, no out__RDY.
  - A fresh lookup then completes normally.
- **Stats (LPM_WALKER_STATS_EN):** after the three lookups above → stat$lookups=3, stat$memReads=7. Without the macro, both stay 0.
